// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg: shared control-bundle type, ALU op codes and writeback encodings.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [3:0] ALU_ADD        = 4'b0000;
  localparam logic [3:0] ALU_SUB        = 4'b0001;
  localparam logic [3:0] ALU_AND        = 4'b0010;
  localparam logic [3:0] ALU_OR         = 4'b0011;
  localparam logic [3:0] ALU_XOR        = 4'b0100;
  localparam logic [3:0] ALU_SLL        = 4'b0101;
  localparam logic [3:0] ALU_SRL        = 4'b0110;
  localparam logic [3:0] ALU_SRA        = 4'b0111;
  localparam logic [3:0] ALU_SLT        = 4'b1000;
  localparam logic [3:0] ALU_SLTU       = 4'b1001;
  localparam logic [3:0] ALU_PASS_B     = 4'b1010;
  localparam logic [3:0] ALU_MIN_U      = 4'b1101;
  localparam logic [3:0] ALU_ABS_DIFF_U = 4'b1110;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef struct packed {
    logic       reg_write_en;
    logic       mem_read_en;
    logic       mem_write_en;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_hazard_detect.sv
// ============================================================================
// hazard_detect: combinational load-use comparator between EX and ID.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_detect (
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  output logic       lu_hazard_o
);

  // rs2 is compared for every format; a false stall costs one cycle only.
  assign lu_hazard_o = ex_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0) & id_valid_i &
                       ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage: ID/EX pipeline register with load-use bubbles, flush and hold.
// Optional performance counters enabled by macro ID_EX_PERF_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic             id_reg_write_en,
  input  logic             id_mem_read_en,
  input  logic             id_mem_write_en,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic             id_jalr,
  input  logic [1:0]       id_mem_to_reg,
  input  logic [1:0]       id_alu_src_a,
  input  logic [1:0]       id_alu_src_b,
  input  logic [3:0]       id_alu_op,
  input  logic             flush_ex,
  input  logic             mem_stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_reg_write_en,
  output logic             ex_mem_read_en,
  output logic             ex_mem_write_en,
  output logic             ex_branch,
  output logic             ex_jump,
  output logic             ex_jalr,
  output logic [1:0]       ex_mem_to_reg,
  output logic [1:0]       ex_alu_src_a,
  output logic [1:0]       ex_alu_src_b,
  output logic [3:0]       ex_alu_op,
  output logic             stall_if_id,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_bubble_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
  } data_t;

  logic  ex_valid_q, ex_valid_d;
  ctrl_t ex_ctrl_q,  ex_ctrl_d;
  data_t ex_data_q,  ex_data_d;
  ctrl_t id_ctrl;
  data_t id_data;
  logic  lu_hazard;

  // Invalid ID slots carry no side effects into EX.
  assign id_ctrl = id_valid ? '{reg_write_en: id_reg_write_en, mem_read_en: id_mem_read_en,
                                mem_write_en: id_mem_write_en, branch: id_branch,
                                jump: id_jump, jalr: id_jalr, mem_to_reg: id_mem_to_reg,
                                alu_src_a: id_alu_src_a, alu_src_b: id_alu_src_b,
                                alu_op: id_alu_op}
                            : CTRL_NOP;

  assign id_data = '{pc: id_pc, rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm,
                     rs1: id_rs1, rs2: id_rs2, rd: id_rd, funct3: id_funct3};

  hazard_detect u_hazard_detect (
    .ex_valid_i    (ex_valid_q),
    .ex_mem_read_i (ex_ctrl_q.mem_read_en),
    .ex_rd_i       (ex_data_q.rd),
    .id_valid_i    (id_valid),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .lu_hazard_o   (lu_hazard)
  );

  assign stall_if_id = ~flush_ex & (mem_stall | lu_hazard);

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_ctrl_d  = ex_ctrl_q;
    ex_data_d  = ex_data_q;
    if (flush_ex || (!mem_stall && lu_hazard)) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = CTRL_NOP;
      ex_data_d  = '0;
    end else if (!mem_stall) begin
      ex_valid_d = id_valid;
      ex_ctrl_d  = id_ctrl;
      ex_data_d  = id_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= CTRL_NOP;
      ex_data_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_data_q  <= ex_data_d;
    end
  end

  assign ex_valid        = ex_valid_q;
  assign ex_pc           = ex_data_q.pc;
  assign ex_rs1_data     = ex_data_q.rs1_data;
  assign ex_rs2_data     = ex_data_q.rs2_data;
  assign ex_imm          = ex_data_q.imm;
  assign ex_rs1          = ex_data_q.rs1;
  assign ex_rs2          = ex_data_q.rs2;
  assign ex_rd           = ex_data_q.rd;
  assign ex_funct3       = ex_data_q.funct3;
  assign ex_reg_write_en = ex_ctrl_q.reg_write_en;
  assign ex_mem_read_en  = ex_ctrl_q.mem_read_en;
  assign ex_mem_write_en = ex_ctrl_q.mem_write_en;
  assign ex_branch       = ex_ctrl_q.branch;
  assign ex_jump         = ex_ctrl_q.jump;
  assign ex_jalr         = ex_ctrl_q.jalr;
  assign ex_mem_to_reg   = ex_ctrl_q.mem_to_reg;
  assign ex_alu_src_a    = ex_ctrl_q.alu_src_a;
  assign ex_alu_src_b    = ex_ctrl_q.alu_src_b;
  assign ex_alu_op       = ex_ctrl_q.alu_op;

`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q, flush_cnt_q;
  logic             bubble_ins;

  assign bubble_ins = ~flush_ex & ~mem_stall & lu_hazard;

  // All three counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (stall_if_id && (stall_cnt_q != '1))   stall_cnt_q  <= stall_cnt_q + CNT_W'(1);
      if (bubble_ins && (bubble_cnt_q != '1))   bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      if (flush_ex && (flush_cnt_q != '1))      flush_cnt_q  <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
  assign perf_flush_cnt  = flush_cnt_q;
`else
  assign perf_stall_cnt  = '0;
  assign perf_bubble_cnt = '0;
  assign perf_flush_cnt  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// tb_id_ex_stage: table-driven directed checks for id_ex_stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;
`ifdef ID_EX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0;
  logic [XLEN-1:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [2:0] id_funct3 = '0;
  logic id_reg_write_en = 0, id_mem_read_en = 0, id_mem_write_en = 0;
  logic id_branch = 0, id_jump = 0, id_jalr = 0;
  logic [1:0] id_mem_to_reg = '0, id_alu_src_a = '0, id_alu_src_b = '0;
  logic [3:0] id_alu_op = '0;
  logic flush_ex = 0, mem_stall = 0;

  logic ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_funct3;
  logic ex_reg_write_en, ex_mem_read_en, ex_mem_write_en, ex_branch, ex_jump, ex_jalr;
  logic [1:0] ex_mem_to_reg, ex_alu_src_a, ex_alu_src_b;
  logic [3:0] ex_alu_op;
  logic stall_if_id;
  logic [CNT_W-1:0] perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_reg_write_en(id_reg_write_en), .id_mem_read_en(id_mem_read_en),
    .id_mem_write_en(id_mem_write_en), .id_branch(id_branch), .id_jump(id_jump),
    .id_jalr(id_jalr), .id_mem_to_reg(id_mem_to_reg), .id_alu_src_a(id_alu_src_a),
    .id_alu_src_b(id_alu_src_b), .id_alu_op(id_alu_op), .flush_ex(flush_ex),
    .mem_stall(mem_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_reg_write_en(ex_reg_write_en), .ex_mem_read_en(ex_mem_read_en),
    .ex_mem_write_en(ex_mem_write_en), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_jalr(ex_jalr), .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src_a(ex_alu_src_a),
    .ex_alu_src_b(ex_alu_src_b), .ex_alu_op(ex_alu_op), .stall_if_id(stall_if_id),
    .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt),
    .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic [3:0] op;
    logic       mr, rw, fl, ms;
    logic       e_st, e_v;
    logic [4:0] e_rd;
    logic [3:0] e_op;
    logic       e_mr, e_rw;
  } vec_t;

  vec_t vecs [15];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, rs2, rd,
                              input logic [3:0] op, input logic mr, rw, fl, ms,
                              input logic e_st, e_v, input logic [4:0] e_rd,
                              input logic [3:0] e_op, input logic e_mr, e_rw);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.op = op; t.mr = mr; t.rw = rw;
    t.fl = fl; t.ms = ms; t.e_st = e_st; t.e_v = e_v; t.e_rd = e_rd; t.e_op = e_op;
    t.e_mr = e_mr; t.e_rw = e_rw;
    return t;
  endfunction

  task automatic check_zero_state(input string tag);
    chk({tag, "_ex_valid"}, 64'(ex_valid), 64'd0);
    chk({tag, "_ex_rd"}, 64'(ex_rd), 64'd0);
    chk({tag, "_ex_pc"}, 64'(ex_pc), 64'd0);
    chk({tag, "_ex_ctrl"}, 64'({ex_reg_write_en, ex_mem_read_en, ex_mem_write_en, ex_branch,
                               ex_jump, ex_jalr, ex_mem_to_reg, ex_alu_src_a, ex_alu_src_b,
                               ex_alu_op}), 64'd0);
    chk({tag, "_stall_cnt"}, 64'(perf_stall_cnt), 64'd0);
    chk({tag, "_bubble_cnt"}, 64'(perf_bubble_cnt), 64'd0);
    chk({tag, "_flush_cnt"}, 64'(perf_flush_cnt), 64'd0);
  endtask

  initial begin
    //              v  rs1 rs2 rd  op     mr rw fl ms | st v  rd  op     mr rw
    vecs[0]  = mk(1, 1,  2,  5,  4'd0,  0, 1, 0, 0,  0, 1, 5,  4'd0,  0, 1); // ADD x5
    vecs[1]  = mk(1, 1,  0,  3,  4'd0,  1, 1, 0, 0,  0, 1, 3,  4'd0,  1, 1); // LW x3
    vecs[2]  = mk(1, 3,  4,  6,  4'd0,  0, 1, 0, 0,  1, 0, 0,  4'd0,  0, 0); // load-use bubble
    vecs[3]  = mk(1, 3,  4,  6,  4'd0,  0, 1, 0, 0,  0, 1, 6,  4'd0,  0, 1); // ADD captured
    vecs[4]  = mk(1, 0,  0,  0,  4'd0,  1, 1, 0, 0,  0, 1, 0,  4'd0,  1, 1); // LW x0
    vecs[5]  = mk(1, 0,  0,  7,  4'd0,  0, 1, 0, 0,  0, 1, 7,  4'd0,  0, 1); // x0 exempt
    vecs[6]  = mk(1, 8,  9,  10, 4'd13, 0, 1, 0, 0,  0, 1, 10, 4'd13, 0, 1); // MIN_U
    vecs[7]  = mk(1, 8,  9,  11, 4'd14, 0, 1, 0, 0,  0, 1, 11, 4'd14, 0, 1); // ABS_DIFF_U
    vecs[8]  = mk(0, 1,  2,  12, 4'd3,  1, 1, 0, 0,  0, 0, 12, 4'd0,  0, 0); // invalid
    vecs[9]  = mk(1, 1,  2,  4,  4'd0,  1, 1, 0, 0,  0, 1, 4,  4'd0,  1, 1); // LW x4
    vecs[10] = mk(1, 4,  0,  9,  4'd0,  0, 1, 1, 1,  0, 0, 0,  4'd0,  0, 0); // flush wins
    vecs[11] = mk(1, 1,  2,  4,  4'd0,  1, 1, 0, 0,  0, 1, 4,  4'd0,  1, 1); // LW x4
    vecs[12] = mk(1, 0,  4,  9,  4'd0,  0, 1, 0, 1,  1, 1, 4,  4'd0,  1, 1); // hold wins
    vecs[13] = mk(1, 0,  4,  9,  4'd0,  0, 1, 0, 0,  1, 0, 0,  4'd0,  0, 0); // then bubble
    vecs[14] = mk(1, 0,  4,  9,  4'd0,  0, 1, 0, 0,  0, 1, 9,  4'd0,  0, 1); // captured

    #2;
    check_zero_state("reset");
    chk("reset_stall", 64'(stall_if_id), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      id_valid = vecs[i].v; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; id_rd = vecs[i].rd;
      id_alu_op = vecs[i].op; id_mem_read_en = vecs[i].mr; id_reg_write_en = vecs[i].rw;
      flush_ex = vecs[i].fl; mem_stall = vecs[i].ms;
      id_pc = 32'h1000 + 32'(i * 4);
      #1;
      chk($sformatf("v%0d_stall", i), 64'(stall_if_id), 64'(vecs[i].e_st));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ex_valid", i), 64'(ex_valid), 64'(vecs[i].e_v));
      chk($sformatf("v%0d_ex_rd", i), 64'(ex_rd), 64'(vecs[i].e_rd));
      chk($sformatf("v%0d_ex_alu_op", i), 64'(ex_alu_op), 64'(vecs[i].e_op));
      chk($sformatf("v%0d_ex_mem_read", i), 64'(ex_mem_read_en), 64'(vecs[i].e_mr));
      chk($sformatf("v%0d_ex_reg_write", i), 64'(ex_reg_write_en), 64'(vecs[i].e_rw));
    end
    chk("tbl_stall_cnt", 64'(perf_stall_cnt), PERF ? 64'd3 : 64'd0);
    chk("tbl_bubble_cnt", 64'(perf_bubble_cnt), PERF ? 64'd2 : 64'd0);
    chk("tbl_flush_cnt", 64'(perf_flush_cnt), PERF ? 64'd1 : 64'd0);

    // Memory hold: fresh reset so the stall counter starts from zero.
    @(negedge clk);
    rst_n = 1'b0; flush_ex = 0; mem_stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    id_valid = 1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd20; id_alu_op = 4'd2;
    id_mem_read_en = 0; id_reg_write_en = 1; id_pc = 32'h2000; id_rs1_data = 32'hCAFE0001;
    @(posedge clk);
    #1;
    chk("cap_ex_pc", 64'(ex_pc), 64'h2000);
    chk("cap_rs1_data", 64'(ex_rs1_data), 64'hCAFE0001);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_stall = 1; id_rd = 5'(21 + k); id_pc = 32'h3000 + 32'(k * 4);
      id_rs1_data = 32'h0BAD0000 + 32'(k);
      #1;
      chk($sformatf("hold%0d_stall", k), 64'(stall_if_id), 64'd1);
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_ex_rd", k), 64'(ex_rd), 64'd20);
      chk($sformatf("hold%0d_ex_pc", k), 64'(ex_pc), 64'h2000);
      chk($sformatf("hold%0d_ex_op", k), 64'(ex_alu_op), 64'd2);
    end
    chk("hold_stall_cnt", 64'(perf_stall_cnt), PERF ? 64'd3 : 64'd0);

    // Asynchronous reset mid-hold.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_state("midrst");
    chk("midrst_stall_follows_mem_stall", 64'(stall_if_id), 64'd1);
    mem_stall = 0;
    #1;
    chk("midrst_stall_clear", 64'(stall_if_id), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    id_rd = 5'd25; id_pc = 32'h4000;
    @(posedge clk);
    #1;
    chk("post_rst_ex_valid", 64'(ex_valid), 64'd1);
    chk("post_rst_ex_rd", 64'(ex_rd), 64'd25);
    chk("post_rst_ex_pc", 64'(ex_pc), 64'h4000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between instruction decode and execute. It captures the control bundle from `control_unit` together with the decoded operands. It detects load-use hazards and inserts bubbles. It honours branch/jump flushes from EX and memory-stall holds from MEM, and exports a stall request to the IF/ID register.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `CNT_W`, 32, width of the performance counters.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `id_valid`  in  1  ID holds a real instruction
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm`  in  XLEN  decoded operands
- `id_rs1`, `id_rs2`, `id_rd`  in  5  register indices
- `id_funct3`  in  3  forwarded to EX/MEM for branch and load/store type
- `id_reg_write_en`, `id_mem_read_en`, `id_mem_write_en`, `id_branch`, `id_jump`, `id_jalr`  in  1  control from `control_unit`
- `id_mem_to_reg`, `id_alu_src_a`, `id_alu_src_b`  in  2  control from `control_unit`
- `id_alu_op`  in  4  control from `control_unit`
- `flush_ex`  in  1  taken branch or jump resolved in EX this cycle
- `mem_stall`  in  1  MEM stage cannot accept a new instruction
- `ex_valid`  out  1  EX register holds a real instruction
- `ex_*`  out  same widths as the `id_*` inputs, registered copies
- `stall_if_id`  out  1  hold PC and the IF/ID register this cycle (combinational)
- `perf_stall_cnt`, `perf_bubble_cnt`, `perf_flush_cnt`  out  CNT_W  performance counters

## Operation
- **Load-use hazard (`lu_hazard`).** Asserted when `ex_valid & ex_mem_read_en & ex_rd != 0 & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2)`.
  - The check is conservative: `id_rs2` is compared for every format.
- **Per-edge priority**, highest first:
  1. `flush_ex` → bubble. All `ex_*` control bits are 0, `ex_valid` = 0, and data fields are don't-care (zeroed in RTL).
  2. `mem_stall` → hold every EX register.
  3. `lu_hazard` → bubble.
  4. Otherwise capture every `id_*` into `ex_*`, and set `ex_valid` from `id_valid`.
- **Stall request:** `stall_if_id = ~flush_ex & (mem_stall | lu_hazard)`.
  - A flush never stalls. IF/ID is flushed separately by the fetch logic.
- **Invalid instructions:** when `id_valid` = 0, the capture path forces all control bits to 0. `ex_valid` = 0 implies no architectural side effect.
- **Hazard duration:** a load-use hazard lasts exactly one cycle, because the inserted bubble clears `ex_mem_read_en`.
- **Custom ops:** `id_alu_op` values 1101 (`MIN_U`) and 1110 (`ABS_DIFF_U`) pass through unchanged.

## Timing
- **Latency:** 1 cycle from `id_*` to `ex_*`.
- **Combinational paths:** `stall_if_id` is the only combinational output. Its path is `ex_*` regs + `id_rs*` + `flush_ex` + `mem_stall`.
- **Reset:** `rst_n` low sets, immediately and asynchronously:
  - `ex_valid`, every `ex_*` control and data output, and all counters to 0;
  - `stall_if_id` follows its equation using the reset register values.
- **Reset mid-stall:** a hold or bubble in progress is discarded. The first edge after release captures ID normally.
- **Simultaneous events:**
  - `flush_ex` with `mem_stall`: the flush wins. The instruction in EX is squashed even if MEM is stalled; the MEM stage owns its own hold.
  - `mem_stall` with `lu_hazard`: the hold wins, no bubble is inserted, and the hazard re-evaluates next cycle.

## Configuration
- Macro: `ID_EX_PERF_CNT_EN`.
- **Defined:**
  - `perf_stall_cnt` increments on every cycle with `stall_if_id` = 1;
  - `perf_bubble_cnt` increments on every bubble insertion caused by `lu_hazard`;
  - `perf_flush_cnt` increments on every `flush_ex` cycle;
  - all three saturate at all-ones.
- **Undefined:** the counter registers are not built, and the three outputs are constant 0. The port list is unchanged.

## Structure
- Shared package `cpu_pkg` holds:
  - `ctrl_t`, a packed struct of the 10 control fields, used for `id_*`/`ex_*` bundling internally;
  - the ALU op localparams (`ALU_ADD` … `ALU_ABS_DIFF_U`);
  - the `mem_to_reg` encodings (`WB_ALU` = 00, `WB_MEM` = 01, `WB_PC4` = 10);
  - `CTRL_NOP`, the all-zero constant.
- One sub-module, `hazard_detect`: a combinational load-use comparator producing `lu_hazard`. It is reusable by a future forwarding unit.

## Test plan
- **Normal capture:** ADD with `id_rd`=5, `id_alu_op`=0000, `id_valid`=1 → next edge `ex_rd`=5, `ex_reg_write_en`=1, `ex_valid`=1; `stall_if_id` stays 0.
- **Load-use stall:**
  - Stimulus: LW x3 in EX, then ID holds ADD with rs1=3.
  - Cycle N: `stall_if_id`=1.
  - Edge N: bubble, `ex_valid`=0.
  - Cycle N+1: `stall_if_id`=0, and ADD captured at edge N+1.
- **x0 exemption:** LW x0 in EX, ID reads rs1=0 → no stall, no bubble.
- **Flush vs. stall:** `flush_ex`=1 with `mem_stall`=1 and `lu_hazard`=1 → `stall_if_id`=0, next `ex_valid`=0 with all controls 0.
- **Memory hold:** `mem_stall`=1 for 3 cycles with ID changing → `ex_*` unchanged for 3 edges; `stall_if_id`=1 throughout.
- **Counters and reset:** with `ID_EX_PERF_CNT_EN` defined, the previous scenario → `perf_stall_cnt`=3. Then `rst_n` pulsed low mid-hold → all outputs 0 immediately, counters 0.
